// File: rtl/merge_pkg.sv
// Shared definitions for the merge load sequencer: state encoding, default sizes, pad element.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package merge_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        MERGE  = 2'd2,
        OUT    = 2'd3
    } state_t;

    // Pad element used when a lone A block is flushed: all-ones sorts after any real data.
    localparam logic [DEF_WIDTH-1:0] PAD_ELEM = {DEF_WIDTH{1'b1}};

endpackage

// File: rtl/merge_lat_cnt.sv
// Loadable down-counter that times the merge unit; done is high whenever the count is zero.
// Latency: done drops the cycle after load and rises again MERGE_LAT cycles later.
// Backpressure: none; counts every cycle until it saturates at zero.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (count cleared, done high)
//   load  reload the count with MERGE_LAT
//   done  count is zero
module merge_lat_cnt #(
    parameter int MERGE_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(MERGE_LAT + 1);

    logic [CW-1:0] cnt;

    // Saturates at zero so an idle counter never wraps back to a large value.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(MERGE_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/merge_load_ctrl.sv
// Sequencer feeding two sorted N-element blocks into the 8+8->16 merge unit and returning its 2N-element result.
// Latency: out_valid rises MERGE_LAT+1 edges after the edge that raises load[1].
// Backpressure: in_ready low while merging or holding a result; the result is held until out_ready.
//
// Optional feature: MERGE_FLUSH_EN adds the flush port, which closes a pair with an all-ones B block.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    upstream block handshake, in_data = one sorted block (element 0 in LSBs)
//   load, inba           merge unit controls: load[0] captures A (inba low half), load[1] captures B (high half)
//   c_in                 merged result from the merge unit
//   out_valid/out_ready  result handshake, out_data = registered copy of c_in
//   busy                 controller is not IDLE
//   flush                (MERGE_FLUSH_EN only) finish a pair with a padded B block
module merge_load_ctrl
    import merge_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int N         = DEF_N,
    parameter int MERGE_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*WIDTH-1:0]     in_data,
    output logic [1:0]             load,
    output logic [2*N*WIDTH-1:0]   inba,
    input  logic [2*N*WIDTH-1:0]   c_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N*WIDTH-1:0]   out_data,
    output logic                   busy
`ifdef MERGE_FLUSH_EN
    ,
    input  logic                   flush
`endif
);

    localparam int BW = N * WIDTH;

    state_t state_q;
    state_t state_d;

    logic take_a;
    logic take_b;
    logic pad_b;
    logic capture;
    logic cnt_done;

    merge_lat_cnt #(
        .MERGE_LAT (MERGE_LAT)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (take_b),
        .done (cnt_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in IDLE/WAIT_B in_ready is high outside reset, so in_valid alone is the handshake.
    always_comb begin
        state_d = state_q;
        take_a  = 1'b0;
        take_b  = 1'b0;
        pad_b   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    take_a  = 1'b1;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (in_valid) begin
                    take_b  = 1'b1;
                    state_d = MERGE;
                end
`ifdef MERGE_FLUSH_EN
                else if (flush) begin
                    take_b  = 1'b1;
                    pad_b   = 1'b1;
                    state_d = MERGE;
                end
`endif
            end
            MERGE: begin
                // Counter was loaded on the B edge, so done here means MERGE_LAT+1 edges have passed.
                if (cnt_done) begin
                    capture = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        if (!rst && (state_q == IDLE || state_q == WAIT_B)) begin
            in_ready = 1'b1;
        end
        if (state_q != IDLE) begin
            busy = 1'b1;
        end
    end

    // Registered outputs to the merge unit and downstream
    always_ff @(posedge clk) begin
        if (rst) begin
            load      <= 2'b00;
            inba      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            // take_a and take_b are mutually exclusive, so load is never 2'b11.
            load <= {take_b, take_a};
            if (take_a) begin
                inba[BW-1:0] <= in_data;
            end
            if (take_b) begin
                // Pad block is every element at its maximum value.
                inba[2*BW-1:BW] <= pad_b ? {BW{1'b1}} : in_data;
            end
            if (capture) begin
                out_data  <= c_in;
                out_valid <= 1'b1;
            end else if (state_q == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merge_load_ctrl.sv
`timescale 1ns/1ps
module tb_merge_load_ctrl;
    import merge_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int N  = DEF_N;
    localparam int ML = 2;
    localparam int BW = N * W;

    localparam logic [BW-1:0]   T2_A   = 64'hD2D0CFCCC9C80000;
    localparam logic [BW-1:0]   T2_B   = 64'h1407060504030201;
    localparam logic [2*BW-1:0] T2_EXP = 128'hD2D0CFCCC9C81407060504030201_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   in_data = '0;
    logic            in_ready, out_valid, busy;
    logic [1:0]      load;
    logic [2*BW-1:0] inba, out_data;
    logic [2*BW-1:0] c_in = '0;
`ifdef MERGE_FLUSH_EN
    logic            flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    merge_load_ctrl #(.WIDTH(W), .N(N), .MERGE_LAT(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .load      (load),
        .inba      (inba),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef MERGE_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2*BW-1:0] got, input logic [2*BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference merge: gather all 2N elements, sort ascending, element 0 in LSBs.
    function automatic logic [2*BW-1:0] merge_ref(input logic [BW-1:0] a, input logic [BW-1:0] b);
        int e[2*N];
        int t;
        logic [2*BW-1:0] r;
        for (int i = 0; i < N; i++) begin
            e[i]     = int'(a[i*W +: W]);
            e[N + i] = int'(b[i*W +: W]);
        end
        for (int i = 0; i < 2*N; i++)
            for (int j = i + 1; j < 2*N; j++)
                if (e[j] < e[i]) begin t = e[i]; e[i] = e[j]; e[j] = t; end
        for (int i = 0; i < 2*N; i++) r[i*W +: W] = W'(e[i]);
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_block();
        int e[N];
        int t;
        logic [BW-1:0] r;
        for (int i = 0; i < N; i++) e[i] = int'($urandom_range(0, (1 << W) - 1));
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++)
                if (e[j] < e[i]) begin t = e[i]; e[i] = e[j]; e[j] = t; end
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(e[i]);
        return r;
    endfunction

    // Stand-in for the merge unit: samples load/inba, result valid one edge after the B sample.
    logic [BW-1:0] ua = '0, ub = '0;
    logic          upend = 1'b0;
    always @(posedge clk) begin
        if (load[0]) ua <= inba[BW-1:0];
        if (load[1]) begin
            ub    <= inba[2*BW-1:BW];
            upend <= 1'b1;
            c_in  <= {(2*N){8'hA5}};
        end else if (upend) begin
            c_in  <= merge_ref(ua, ub);
            upend <= 1'b0;
        end
    end

    // Inputs as seen at each rising edge (they change 2 ns after the edge).
    logic          p_rst = 1'b1, p_in_valid = 1'b0, p_out_ready = 1'b0, edge_seen = 1'b0;
    logic [BW-1:0] p_in_data = '0;
`ifdef MERGE_FLUSH_EN
    logic          p_flush = 1'b0;
`endif
    always @(posedge clk) begin
        p_rst       <= rst;
        p_in_valid  <= in_valid;
        p_in_data   <= in_data;
        p_out_ready <= out_ready;
`ifdef MERGE_FLUSH_EN
        p_flush     <= flush;
`endif
        edge_seen   <= 1'b1;
    end

    // Transaction-level model: pair buffer, one pending result, edge count since the B load.
    int                half = 0;
    bit                occ = 1'b0;
    bit                ov_m = 1'b0;
    int                since = 0;
    logic [1:0]        exp_load = 2'b00;
    logic [BW-1:0]     a_m = '0, b_m = '0;
    logic [2*BW-1:0]   expq[$];

    always @(negedge clk) begin
        if (edge_seen) begin
            if (p_rst) begin
                half = 0; occ = 1'b0; since = 0; exp_load = 2'b00;
                a_m = '0; b_m = '0; expq.delete();
            end else begin
                exp_load = 2'b00;
                if (occ && ov_m && p_out_ready) begin
                    occ = 1'b0;
                    void'(expq.pop_front());
                end else if (!occ && p_in_valid) begin
                    if (half == 0) begin
                        a_m = p_in_data; half = 1; exp_load = 2'b01;
                    end else begin
                        b_m = p_in_data; half = 0; occ = 1'b1; since = 0; exp_load = 2'b10;
                        expq.push_back(merge_ref(a_m, b_m));
                    end
                end
`ifdef MERGE_FLUSH_EN
                else if (!occ && half == 1 && p_flush) begin
                    b_m = {N{PAD_ELEM}}; half = 0; occ = 1'b1; since = 0; exp_load = 2'b10;
                    expq.push_back(merge_ref(a_m, b_m));
                end
`endif
                else if (occ) begin
                    since++;
                end
            end
            ov_m = occ && (since >= ML + 1);
            chk("load", load, exp_load);
            chk("inba", inba, {b_m, a_m});
            chk("out_valid", out_valid, ov_m);
            chk("in_ready", in_ready, !rst && !occ);
            chk("busy", busy, occ || half == 1);
            if (ov_m && expq.size() > 0) chk("out_data", out_data, expq[0]);
            if (p_rst) chk("out_data_rst", out_data, '0);
        end
    end

    // Present a block and hold it until accepted (caller is 2 ns after a rising edge).
    task automatic send(input logic [BW-1:0] d, input bit keep);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #2;
                ok = 1'b1;
            end
        end
        if (!keep) in_valid = 1'b0;
        chk("send_timeout", ok, 1'b1);
    endtask

    // Wait at falling edges for out_valid; returns the 1-based falling-edge index it was seen on.
    task automatic wait_ov(output int n);
        n = 0;
        for (int i = 1; i <= 50 && n == 0; i++) begin
            @(negedge clk);
            if (out_valid) n = i;
        end
        chk("ov_timeout", n != 0, 1'b1);
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (!occ && !out_valid) ok = 1'b1;
        end
        chk("drain_timeout", ok, 1'b1);
        @(posedge clk); #2;
    endtask

    bit rnd_en = 1'b0;
    always @(posedge clk) begin
        if (rnd_en) begin
            #2 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [BW-1:0] blk;

        // T1: reset for two edges
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #2;

        // T2: directed pair, result latency measured from the B accept edge
        out_ready = 1'b1;
        send(T2_A, 1'b0);
        send(T2_B, 1'b0);
        wait_ov(n);
        chk("t2_latency", n, 4);
        chk("t2_result", out_data, T2_EXP);
        drain();

        // T3: hold result under backpressure, third block waits
        out_ready = 1'b0;
        send(T2_A, 1'b0);
        send(T2_B, 1'b0);
        wait_ov(n);
        @(posedge clk); #2;
        blk = rand_block();
        in_valid = 1'b1;
        in_data  = blk;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold", out_data, T2_EXP);
            chk("t3_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #2;
        out_ready = 1'b1;
        send(blk, 1'b0);
        send(rand_block(), 1'b0);
        drain();

        // T4: reset while merging drops the pair
        send(rand_block(), 1'b0);
        send(rand_block(), 1'b0);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_no_valid", out_valid, 1'b0);
        end
        @(posedge clk); #2;
        send(rand_block(), 1'b0);
        send(rand_block(), 1'b0);
        drain();

        // T5: three pairs with in_valid held high throughout
        for (int i = 0; i < 6; i++) send(rand_block(), i != 5);
        drain();

`ifdef MERGE_FLUSH_EN
        // T6: flush a lone A block, then flush together with a real B
        blk = rand_block();
        send(blk, 1'b0);
        repeat (2) @(posedge clk);
        #2 flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        wait_ov(n);
        chk("t6_pad", out_data, {{N{PAD_ELEM}}, blk});
        drain();
        send(T2_A, 1'b0);
        flush = 1'b1;
        send(T2_B, 1'b0);
        flush = 1'b0;
        wait_ov(n);
        chk("t6_flush_with_data", out_data, T2_EXP);
        drain();
`endif

        // Randomised traffic with random gaps and random downstream backpressure
        rnd_en = 1'b1;
        for (int p = 0; p < 40; p++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
            send(rand_block(), 1'b0);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
            send(rand_block(), 1'b0);
        end
        rnd_en = 1'b0;
        @(posedge clk); #3;
        out_ready = 1'b1;
        @(posedge clk); #2;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
